// File: rtl/traffic_pkg.sv
// Shared codes, mode/state enums and code classification helpers for the
// autonomous traffic-light sequencer.
package traffic_pkg;

  localparam logic [4:0] G0    = 5'd0;
  localparam logic [4:0] Y0    = 5'd1;
  localparam logic [4:0] G1    = 5'd2;
  localparam logic [4:0] Y1    = 5'd3;
  localparam logic [4:0] G2    = 5'd4;
  localparam logic [4:0] Y2    = 5'd5;
  localparam logic [4:0] G3    = 5'd6;
  localparam logic [4:0] AR    = 5'd7;
  localparam logic [4:0] FLASH = 5'd8;
  localparam logic [4:0] WARN  = 5'd9;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_FLASH  = 2'b01,
    MODE_ALLRED = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_RUN,
    ST_FLASH,
    ST_ALLRED,
    ST_HOLD
  } state_t;

  function automatic logic is_green(input logic [4:0] c);
    return (c == G0) || (c == G1) || (c == G2) || (c == G3);
  endfunction

  // Yellow phases and the all-red clearance are the only safe mode-switch points.
  function automatic logic is_safe(input logic [4:0] c);
    return (c == Y0) || (c == Y1) || (c == Y2) || (c == AR);
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Loadable seconds down-counter; expire flags the tick that consumes the last second.
module sec_timer #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic         hold,
  output logic [W-1:0] count,
  output logic         expire
);

  assign expire = tick && !hold && (count == W'(1));

  // Load wins over hold so a frozen timer can still be re-armed on a phase change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (tick && !hold && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/traffic_sequencer.sv
// Timed four-approach traffic sequencer producing the decoder cycle code and
// blink enable, with startup, flash-yellow, all-red and hold modes.
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int T_GREEN   = 10,
  parameter int T_BLINK   = 3,
  parameter int T_YELLOW  = 3,
  parameter int T_ALLRED  = 2,
  parameter int T_STARTUP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] mode,
  output logic [4:0] ciclo,
  output logic       blink_en,
  output logic       phase_done
);

  localparam int TM_A = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
  localparam int TM_B = (T_ALLRED > T_STARTUP) ? T_ALLRED : T_STARTUP;
  localparam int TMAX = (TM_A > TM_B) ? TM_A : TM_B;
  localparam int TW   = $clog2(TMAX + 1);

  state_t         state, state_n;
  mode_t          pend, pend_n;
  mode_t          m;
  logic [4:0]     code, code_n;
  logic           blink_n;
  logic           t_load, t_hold, t_expire;
  logic [TW-1:0]  t_val, t_count, cnt_next;

  assign m = mode_t'(mode);

  function automatic logic [TW-1:0] dur_of(input logic [4:0] c);
    if (is_green(c))   return TW'(T_GREEN);
    else if (c == AR)  return TW'(T_ALLRED);
    else if (c == WARN) return TW'(T_STARTUP);
    else               return TW'(T_YELLOW);
  endfunction

  // A 00 request withdraws any pending switch; hold requests leave it untouched.
  function automatic mode_t latch_req(input mode_t cur, input mode_t req);
    if ((req == MODE_FLASH) || (req == MODE_ALLRED)) return req;
    else if (req == MODE_NORMAL)                     return MODE_NORMAL;
    else                                             return cur;
  endfunction

  sec_timer #(
    .W       (TW),
    .RST_VAL (TW'(T_STARTUP))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .tick     (tick),
    .hold     (t_hold),
    .count    (t_count),
    .expire   (t_expire)
  );

  always_comb begin
    state_n = state;
    code_n  = code;
    pend_n  = pend;
    t_load  = 1'b0;
    t_val   = dur_of(code);
    t_hold  = 1'b1;

    case (state)
      ST_STARTUP: begin
        t_hold = 1'b0;
        pend_n = latch_req(pend, m);
        if (t_expire) begin
          state_n = ST_RUN;
          code_n  = AR;
          t_load  = 1'b1;
          t_val   = dur_of(AR);
        end
      end

      ST_RUN: begin
        pend_n = latch_req(pend, m);
        if (m == MODE_HOLD) begin
          state_n = ST_HOLD;
        end else begin
          t_hold = 1'b0;
          if (t_expire) begin
            if (is_safe(code) && (pend_n == MODE_FLASH)) begin
              state_n = ST_FLASH;
              code_n  = FLASH;
              pend_n  = MODE_NORMAL;
            end else if (is_safe(code) && (pend_n == MODE_ALLRED)) begin
              state_n = ST_ALLRED;
              code_n  = AR;
              pend_n  = MODE_NORMAL;
            end else begin
              code_n = (code == AR) ? G0 : code + 5'd1;
              t_load = 1'b1;
              t_val  = dur_of(code_n);
            end
          end
        end
      end

      ST_FLASH, ST_ALLRED: begin
        pend_n = MODE_NORMAL;
        if ((m == MODE_NORMAL) && tick) begin
          state_n = ST_RUN;
          code_n  = AR;
          t_load  = 1'b1;
          t_val   = dur_of(AR);
        end
      end

      ST_HOLD: begin
        if (m != MODE_HOLD) begin
          state_n = ST_RUN;
          pend_n  = latch_req(pend, m);
        end
      end

      default: begin
        state_n = ST_STARTUP;
        code_n  = WARN;
        pend_n  = MODE_NORMAL;
        t_load  = 1'b1;
        t_val   = dur_of(WARN);
      end
    endcase

    if (t_load)
      cnt_next = t_val;
    else if (tick && !t_hold && (t_count != '0))
      cnt_next = t_count - TW'(1);
    else
      cnt_next = t_count;

    // Blink is registered, so it is derived from the values the next cycle will hold.
    blink_n = 1'b0;
    if ((state_n == ST_STARTUP) || (state_n == ST_FLASH))
      blink_n = 1'b1;
    else if (((state_n == ST_RUN) || (state_n == ST_HOLD)) && is_green(code_n) &&
             (cnt_next <= TW'(T_BLINK)))
      blink_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_STARTUP;
      code     <= WARN;
      pend     <= MODE_NORMAL;
      blink_en <= 1'b1;
    end else begin
      state    <= state_n;
      code     <= code_n;
      pend     <= pend_n;
      blink_en <= blink_n;
    end
  end

  assign ciclo      = code;
  assign phase_done = t_expire && rst;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed self-checking bench for traffic_sequencer with hand-computed phase schedules.
module tb_traffic_sequencer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [1:0] mode;
  logic [4:0] ciclo;
  logic       blink_en;
  logic       phase_done;

  int n_cmp = 0;
  int n_err = 0;

  traffic_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .mode       (mode),
    .ciclo      (ciclo),
    .blink_en   (blink_en),
    .phase_done (phase_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_tick(output logic pd);
    @(posedge clk); #1; tick = 1'b1;
    @(negedge clk); pd = phase_done;
    @(posedge clk); #1; tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    logic pd;
    for (int i = 0; i < n; i++) do_tick(pd);
  endtask

  task automatic do_reset();
    rst = 1'b0; tick = 1'b0; mode = 2'b00;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
  endtask

  // Startup (4) plus the first clearance (2) lands at the start of G0.
  task automatic run_startup();
    do_reset();
    do_ticks(6);
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 1'b0; mode = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ciclo !== 5'd9) begin n_err++; $display("[TB] FAIL reset_ciclo got=%0d exp=9", ciclo); end
    n_cmp++;
    if (blink_en !== 1'b1) begin n_err++; $display("[TB] FAIL reset_blink got=%0b exp=1", blink_en); end
    n_cmp++;
    if (phase_done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_phase_done got=%0b exp=0", phase_done); end
    #1; rst = 1'b1;
  endtask

  task automatic test_startup();
    logic pd;
    logic [4:0] exp_c;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      do_tick(pd);
      exp_c = (k < 4) ? 5'd9 : (k < 6) ? 5'd7 : 5'd0;
      n_cmp++;
      if (ciclo !== exp_c) begin n_err++; $display("[TB] FAIL startup_ciclo k=%0d got=%0d exp=%0d", k, ciclo, exp_c); end
      n_cmp++;
      if (pd !== ((k == 4) || (k == 6))) begin n_err++; $display("[TB] FAIL startup_pd k=%0d got=%0b", k, pd); end
    end
    for (int j = 1; j <= 10; j++) begin
      n_cmp++;
      if (blink_en !== (j >= 8)) begin n_err++; $display("[TB] FAIL g0_blink sec=%0d got=%0b exp=%0b", j, blink_en, (j >= 8)); end
      do_tick(pd);
      exp_c = (j < 10) ? 5'd0 : 5'd1;
      n_cmp++;
      if (ciclo !== exp_c) begin n_err++; $display("[TB] FAIL g0_ciclo sec=%0d got=%0d exp=%0d", j, ciclo, exp_c); end
    end
  endtask

  task automatic test_normal_cycle();
    logic pd;
    int pulses;
    int codes [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int durs  [8] = '{10, 3, 10, 3, 10, 3, 10, 2};
    logic exp_b;
    run_startup();
    pulses = 0;
    for (int p = 0; p < 8; p++) begin
      for (int s = 1; s <= durs[p]; s++) begin
        exp_b = ((codes[p] % 2) == 0) && (codes[p] != 7) && ((durs[p] - s + 1) <= 3);
        n_cmp++;
        if (ciclo !== 5'(codes[p])) begin n_err++; $display("[TB] FAIL cycle_ciclo p=%0d s=%0d got=%0d exp=%0d", p, s, ciclo, codes[p]); end
        n_cmp++;
        if (blink_en !== exp_b) begin n_err++; $display("[TB] FAIL cycle_blink p=%0d s=%0d got=%0b exp=%0b", p, s, blink_en, exp_b); end
        do_tick(pd);
        if (pd === 1'b1) pulses++;
        n_cmp++;
        if (pd !== (s == durs[p])) begin n_err++; $display("[TB] FAIL cycle_pd p=%0d s=%0d got=%0b", p, s, pd); end
      end
    end
    n_cmp++;
    if (ciclo !== 5'd0) begin n_err++; $display("[TB] FAIL cycle_wrap got=%0d exp=0", ciclo); end
    n_cmp++;
    if (pulses !== 8) begin n_err++; $display("[TB] FAIL cycle_pulses got=%0d exp=8", pulses); end
  endtask

  task automatic test_flash();
    logic pd;
    run_startup();
    do_ticks(13 + 3);
    mode = 2'b01;
    do_ticks(7);
    n_cmp++;
    if (ciclo !== 5'd3) begin n_err++; $display("[TB] FAIL flash_g1_done got=%0d exp=3", ciclo); end
    do_ticks(2);
    n_cmp++;
    if (ciclo !== 5'd3) begin n_err++; $display("[TB] FAIL flash_y1_hold got=%0d exp=3", ciclo); end
    do_tick(pd);
    n_cmp++;
    if (ciclo !== 5'd8) begin n_err++; $display("[TB] FAIL flash_enter got=%0d exp=8", ciclo); end
    for (int k = 0; k < 3; k++) begin
      do_tick(pd);
      n_cmp++;
      if ((ciclo !== 5'd8) || (blink_en !== 1'b1) || (pd !== 1'b0)) begin
        n_err++; $display("[TB] FAIL flash_stay k=%0d got=%0d/%0b/%0b exp=8/1/0", k, ciclo, blink_en, pd);
      end
    end
    mode = 2'b00;
    @(posedge clk); #1;
    n_cmp++;
    if (ciclo !== 5'd8) begin n_err++; $display("[TB] FAIL flash_wait_tick got=%0d exp=8", ciclo); end
    do_tick(pd);
    n_cmp++;
    if ((ciclo !== 5'd7) || (blink_en !== 1'b0)) begin n_err++; $display("[TB] FAIL flash_exit got=%0d/%0b exp=7/0", ciclo, blink_en); end
    do_tick(pd);
    n_cmp++;
    if (ciclo !== 5'd7) begin n_err++; $display("[TB] FAIL flash_clear got=%0d exp=7", ciclo); end
    do_tick(pd);
    n_cmp++;
    if (ciclo !== 5'd0) begin n_err++; $display("[TB] FAIL flash_resume got=%0d exp=0", ciclo); end
  endtask

  task automatic test_allred();
    logic pd;
    run_startup();
    do_ticks(10);
    mode = 2'b10;
    do_ticks(2);
    n_cmp++;
    if (ciclo !== 5'd1) begin n_err++; $display("[TB] FAIL allred_y0 got=%0d exp=1", ciclo); end
    do_tick(pd);
    for (int k = 0; k < 5; k++) begin
      do_tick(pd);
      n_cmp++;
      if ((ciclo !== 5'd7) || (blink_en !== 1'b0) || (pd !== 1'b0)) begin
        n_err++; $display("[TB] FAIL allred_stay k=%0d got=%0d/%0b/%0b exp=7/0/0", k, ciclo, blink_en, pd);
      end
    end
    mode = 2'b00;
    do_ticks(2);
    n_cmp++;
    if (ciclo !== 5'd7) begin n_err++; $display("[TB] FAIL allred_clear got=%0d exp=7", ciclo); end
    do_tick(pd);
    n_cmp++;
    if (ciclo !== 5'd0) begin n_err++; $display("[TB] FAIL allred_resume got=%0d exp=0", ciclo); end
  endtask

  task automatic test_simultaneous();
    logic pd;
    run_startup();
    do_ticks(12);
    @(posedge clk); #1; tick = 1'b1; mode = 2'b01;
    @(posedge clk); #1; tick = 1'b0;
    n_cmp++;
    if (ciclo !== 5'd8) begin n_err++; $display("[TB] FAIL simul_flash got=%0d exp=8", ciclo); end
    mode = 2'b00;
    do_tick(pd);
    n_cmp++;
    if (ciclo !== 5'd7) begin n_err++; $display("[TB] FAIL simul_exit got=%0d exp=7", ciclo); end
  endtask

  task automatic test_hold();
    logic pd;
    run_startup();
    do_ticks(26 + 5);
    mode = 2'b11;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      do_tick(pd);
      n_cmp++;
      if ((ciclo !== 5'd4) || (pd !== 1'b0)) begin n_err++; $display("[TB] FAIL hold_freeze k=%0d got=%0d/%0b exp=4/0", k, ciclo, pd); end
    end
    #1; mode = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      do_tick(pd);
      n_cmp++;
      if (ciclo !== ((k < 5) ? 5'd4 : 5'd5)) begin n_err++; $display("[TB] FAIL hold_resume k=%0d got=%0d exp=%0d", k, ciclo, (k < 5) ? 4 : 5); end
    end
  endtask

  task automatic test_hold_in_startup();
    do_reset();
    mode = 2'b11;
    do_ticks(4);
    mode = 2'b00;
    n_cmp++;
    if (ciclo !== 5'd7) begin n_err++; $display("[TB] FAIL startup_hold_ignored got=%0d exp=7", ciclo); end
  endtask

  task automatic test_cancel();
    run_startup();
    do_ticks(3);
    mode = 2'b10;
    @(posedge clk); #1;
    mode = 2'b00;
    do_ticks(7);
    n_cmp++;
    if (ciclo !== 5'd1) begin n_err++; $display("[TB] FAIL cancel_y0 got=%0d exp=1", ciclo); end
    do_ticks(3);
    n_cmp++;
    if (ciclo !== 5'd2) begin n_err++; $display("[TB] FAIL cancel_no_allred got=%0d exp=2", ciclo); end
  endtask

  task automatic test_reset_mid();
    logic pd;
    run_startup();
    do_ticks(37);
    n_cmp++;
    if (ciclo !== 5'd5) begin n_err++; $display("[TB] FAIL mid_in_y2 got=%0d exp=5", ciclo); end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_cmp++;
    if ((ciclo !== 5'd9) || (blink_en !== 1'b1) || (phase_done !== 1'b0)) begin
      n_err++; $display("[TB] FAIL mid_reset got=%0d/%0b/%0b exp=9/1/0", ciclo, blink_en, phase_done);
    end
    for (int k = 1; k <= 4; k++) begin
      do_tick(pd);
      n_cmp++;
      if (ciclo !== ((k < 4) ? 5'd9 : 5'd7)) begin n_err++; $display("[TB] FAIL mid_replay k=%0d got=%0d", k, ciclo); end
    end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; mode = 2'b00;
    test_reset();
    test_startup();
    test_normal_cycle();
    test_flash();
    test_allred();
    test_simultaneous();
    test_hold();
    test_hold_in_startup();
    test_cancel();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
